// File: rtl/addr_calc_pkg.sv
// Shared address-path constants and payload types for the forward calculator
// and for its inverse (addr_recover_pipe).
package addr_calc_pkg;

    localparam int AW = 8;
    localparam int CW = 16;
    localparam logic [AW-1:0] BASE = 8'h80;

    typedef struct packed {
        logic [CW-1:0] r;
        logic [AW-1:0] ptr1;
        logic [AW-1:0] ptr2;
    } stage1_t;

    typedef struct packed {
        logic [AW-1:0] ptr_rec;
        logic          control_rec;
        logic          hit;
        logic          range_err;
    } result_t;

    // ptr1 wins when both candidates match; anything outside AW bits is a miss.
    function automatic result_t decode(stage1_t s);
        result_t res;
        logic    m1;
        logic    m2;
        logic    rerr;
        rerr            = |s.r[CW-1:AW];
        m1              = (s.r == {{(CW-AW){1'b0}}, s.ptr1});
        m2              = (s.r == {{(CW-AW){1'b0}}, s.ptr2});
        res.ptr_rec     = s.r[AW-1:0];
        res.control_rec = m1 & ~rerr;
        res.hit         = (m1 | m2) & ~rerr;
        res.range_err   = rerr;
        return res;
    endfunction

endpackage

// File: rtl/addr_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module addr_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (en && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/addr_recover_pipe.sv
// Inverse address calculator: recovers pointer offset and control from a count.
// Two-stage valid/ready pipeline with saturating hit/miss statistics.
module addr_recover_pipe #(
    parameter logic [7:0] BASE = addr_calc_pkg::BASE,
    parameter int         CW   = addr_calc_pkg::CW,
    parameter int         AW   = addr_calc_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] count,
    input  logic [AW-1:0] address,
    input  logic [AW-1:0] b,
    input  logic [AW-1:0] ptr1,
    input  logic [AW-1:0] ptr2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] ptr_rec,
    output logic          control_rec,
    output logic          hit,
    output logic          range_err,
    output logic [CW-1:0] hit_cnt,
    output logic [CW-1:0] miss_cnt
);

    localparam int STAGES = 2;

    // Payload widths come from the shared package; parameters must agree with it.
    logic [STAGES:1]         vld_pipe;
    addr_calc_pkg::stage1_t  s1_q;
    addr_calc_pkg::result_t  res_q;
    logic                    s2_ready;
    logic                    in_acc;
    logic                    xfer;
    logic [CW-1:0]           r_calc;

    assign s2_ready = ~vld_pipe[2] | out_ready;
    assign in_ready = ~vld_pipe[1] | s2_ready;
    assign in_acc   = in_valid & in_ready;
    assign xfer     = vld_pipe[2] & out_ready;

    // Undo address - BASE + b modulo 2^CW; underflow shows up as range_err later.
    assign r_calc = count - CW'(address) + CW'(BASE) - CW'(b);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            res_q    <= '0;
        end else begin
            if (in_ready) begin
                vld_pipe[1] <= in_valid;
                if (in_acc)
                    s1_q <= '{r: r_calc, ptr1: ptr1, ptr2: ptr2};
            end
            if (s2_ready) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1])
                    res_q <= addr_calc_pkg::decode(s1_q);
            end
        end
    end

    assign out_valid   = vld_pipe[2];
    assign ptr_rec     = res_q.ptr_rec;
    assign control_rec = res_q.control_rec;
    assign hit         = res_q.hit;
    assign range_err   = res_q.range_err;

    addr_sat_counter #(.W(CW)) u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .en  (xfer & res_q.hit),
        .cnt (hit_cnt)
    );

    addr_sat_counter #(.W(CW)) u_miss_cnt (
        .clk (clk),
        .rst (rst),
        .en  (xfer & ~res_q.hit),
        .cnt (miss_cnt)
    );

endmodule

// File: doc/addr_recover_pipe.md
Name: addr_recover_pipe

Overview:
- Inverse of the forward address calculator. The forward function is count = address - base + ptr + b, with a late control selecting ptr1 (control=1) or ptr2 (control=0).
- This block takes a count, the same operands and a candidate pointer pair, and recovers the pointer offset and the control value that produced the count.
- It sits on the consumer side of the address path. It is a 2-stage valid/ready pipeline with hit/miss statistics counters.

Parameters:
- BASE, 8'h80, constant base subtracted in the forward path.
- CW, 16, count/statistics width.
- AW, 8, operand width (address, ptr1, ptr2, b).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- count  in  CW  count to decompose.
- address  in  AW  operand, sampled with the beat.
- b  in  AW  operand, sampled with the beat.
- ptr1  in  AW  candidate pointer for control=1.
- ptr2  in  AW  candidate pointer for control=0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- ptr_rec  out  AW  recovered offset r[AW-1:0].
- control_rec  out  1  1 = matched ptr1, 0 = matched ptr2 or miss.
- hit  out  1  r equals zero-extended ptr1 or ptr2.
- range_err  out  1  r[CW-1:AW] != 0; hit is forced to 0 when set.
- hit_cnt  out  CW  saturating count of delivered hits.
- miss_cnt  out  CW  saturating count of delivered misses.

Behaviour:
- Reset (synchronous, rst high at a clock edge):
  - Both stage valids clear; out_valid=0.
  - ptr_rec=0, control_rec=0, hit=0, range_err=0, hit_cnt=0, miss_cnt=0.
  - in_ready=1 from the first cycle after reset.
  - rst mid-operation discards all in-flight beats; no partial outputs are produced.
- Stage 1 (on accept):
  - Register r = count - {0,address} + {0,BASE} - {0,b}, computed modulo 2^CW with operands zero-extended to CW.
  - Register ptr1 and ptr2 alongside r.
- Stage 2: register the results.
  - m1 = (r == {0,ptr1}); m2 = (r == {0,ptr2}).
  - hit = (m1|m2) & ~range_err.
  - control_rec = m1 & ~range_err. Priority goes to ptr1 when both match.
  - ptr_rec = r[AW-1:0] regardless of hit.
- Latency and throughput:
  - Latency is 2 cycles from accept to out_valid when there is no backpressure.
  - Throughput is 1 beat/cycle.
- Handshake:
  - Each stage advances when its successor is empty or is being drained that cycle.
  - in_ready = ~s1_valid | s2_advance. It is combinational from out_ready; no extra skid buffer is used.
  - Output payload holds stable while out_valid & ~out_ready. out_valid never drops without a transfer.
  - Simultaneous accept and deliver in the same cycle is allowed: the pipeline shifts and no beat is lost.
- Statistics counters:
  - They update only on an output transfer (out_valid & out_ready).
  - hit_cnt increments on hit; miss_cnt increments otherwise, including range_err.
  - Both saturate at all-ones and do not wrap.
- Wrap-around: a count below address-BASE+b wraps in r and normally sets range_err. No exception is raised.

Decomposition:
- Package addr_calc_pkg holds:
  - BASE, AW, CW constants.
  - A typedef for the stage-1 payload {r, ptr1, ptr2}.
  - A typedef for the result {ptr_rec, control_rec, hit, range_err}.
- The same package is shared with the forward calculator so BASE is defined once.
- One natural sub-module, addr_sat_counter: CW-bit counter with synchronous reset, increment enable and saturation. It is instantiated twice.

Test Plan:
Common operands for scenarios 1-4: BASE=0x80, address=0x90, b=0x03, ptr1=0x05, ptr2=0x07.
- ptr1 hit: count=0x0018, out_ready=1 -> 2 cycles later out_valid=1, ptr_rec=0x05, control_rec=1, hit=1, range_err=0, hit_cnt=1.
- ptr2 hit and priority:
  - count=0x001A -> ptr_rec=0x07, control_rec=0, hit=1.
  - Repeat with ptr1=ptr2=0x05 and count=0x0018 -> control_rec=1.
- Miss and wrap:
  - count=0x0020 -> ptr_rec=0x0D, hit=0, miss_cnt=1.
  - count=0x0000 -> r=0xFFED, range_err=1, hit=0, ptr_rec=0xED.
- Backpressure: stream 4 beats with out_ready held low 5 cycles.
  - in_ready drops after 2 beats are accepted.
  - Output holds the first result stable.
  - After release, all 4 results appear in order with no loss or duplication.
- Reset and saturation:
  - Assert rst with 2 beats in flight -> next cycle out_valid=0, counters=0, and no stale beat emerges.
  - Force hit_cnt to 0xFFFE, then deliver 3 hits -> hit_cnt stays at 0xFFFF.
